// File: rtl/column_timer_if.sv
// Bus between column_timer and the column/LED read controller.
// master: read-control FSM side; slave: the timer itself.
interface column_timer_if #(
  parameter int unsigned COL_SHIFT = 8,
  parameter int unsigned CNT_W     = 24
);
  logic                 load_crt;
  logic                 reset_new;
  logic                 new_col;
  logic                 done_crt;
  logic [COL_SHIFT-1:0] col_idx;
  logic                 period_valid;
  logic [CNT_W-1:0]     interval;

  modport master (
    output load_crt, reset_new,
    input  new_col, done_crt, col_idx, period_valid, interval
  );

  modport slave (
    input  load_crt, reset_new,
    output new_col, done_crt, col_idx, period_valid, interval
  );
endinterface

// File: rtl/column_timer.sv
// Column-rate timer for the POV display.
// Measures the rotor period from the hall sensor and, on load_crt, sweeps
// 2^COL_SHIFT equal column slots, flagging each slot on new_col and the end
// of the sweep on done_crt.
// Optional: define SYNC_ON_HALL_EN to let an accepted hall edge end a running
// sweep early, realigning column 0 with the index mark.
module column_timer #(
  parameter int unsigned COL_SHIFT  = 8,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned MIN_PERIOD = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hall,
  column_timer_if.slave bus
);

  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]     MIN_P    = CNT_W'(MIN_PERIOD);
  localparam logic [COL_SHIFT-1:0] LAST_COL = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // hall synchroniser / period measurement
  logic             hall_meta_q, hall_meta_d;
  logic             hall_sync_q, hall_sync_d;
  logic             hall_prev_q, hall_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pvalid_q, pvalid_d;
  logic             hall_rise, hall_acc, timed_out, sync_end;
  logic [CNT_W-1:0] shifted, ival;

  // column sweep
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     down_q, down_d;
  logic [CNT_W-1:0]     sweep_ival_q, sweep_ival_d;
  logic [COL_SHIFT-1:0] col_q, col_d;
  logic                 done_q, done_d;
  logic                 new_col_q, new_col_d;

  // Synchronise hall, qualify edges against MIN_PERIOD, latch the period.
  // A saturated counter is a timeout: the next edge restarts acquisition.
  always_comb begin
    hall_meta_d = hall;
    hall_sync_d = hall_meta_q;
    hall_prev_d = hall_sync_q;
    hall_rise   = hall_sync_q & ~hall_prev_q;
    timed_out   = (cnt_q == CNT_MAX);
    hall_acc    = hall_rise && (first_q || timed_out || (cnt_q >= MIN_P));
    cnt_d       = timed_out ? cnt_q : cnt_q + 1'b1;
    first_d     = first_q | timed_out;
    pvalid_d    = pvalid_q & ~timed_out;
    period_d    = period_q;
    if (hall_acc) begin
      cnt_d   = CNT_W'(1);
      first_d = 1'b0;
      if (!(first_q || timed_out)) begin
        period_d = cnt_q;
        pvalid_d = 1'b1;
      end
    end
    shifted = period_q >> COL_SHIFT;
    ival    = '0;
    if (period_q != '0) ival = (shifted == '0) ? CNT_W'(1) : shifted;
  end

  // Measurement registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hall_meta_q <= 1'b0;
      hall_sync_q <= 1'b0;
      hall_prev_q <= 1'b0;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      period_q    <= '0;
      pvalid_q    <= 1'b0;
    end else begin
      hall_meta_q <= hall_meta_d;
      hall_sync_q <= hall_sync_d;
      hall_prev_q <= hall_prev_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      period_q    <= period_d;
      pvalid_q    <= pvalid_d;
    end
  end

`ifdef SYNC_ON_HALL_EN
  assign sync_end = hall_acc;
`else
  assign sync_end = 1'b0;
`endif

  // Sweep FSM: interval is captured at load so a mid-sweep period change
  // only affects the next sweep. A tick setting new_col beats reset_new.
  always_comb begin
    state_d      = state_q;
    down_d       = down_q;
    sweep_ival_d = sweep_ival_q;
    col_d        = col_q;
    done_d       = done_q;
    new_col_d    = new_col_q & ~bus.reset_new;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.load_crt && pvalid_q) begin
          state_d      = S_RUN;
          col_d        = '0;
          done_d       = 1'b0;
          sweep_ival_d = ival;
          down_d       = ival - 1'b1;
        end
      end
      S_RUN: begin
        if (sync_end) begin
          done_d  = 1'b1;
          col_d   = '0;
          state_d = S_DONE;
        end else if (down_q == '0) begin
          new_col_d = 1'b1;
          col_d     = col_q + 1'b1;
          down_d    = sweep_ival_q - 1'b1;
          if (col_q == LAST_COL) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          down_d = down_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sweep registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      down_q       <= '0;
      sweep_ival_q <= '0;
      col_q        <= '0;
      done_q       <= 1'b0;
      new_col_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      down_q       <= down_d;
      sweep_ival_q <= sweep_ival_d;
      col_q        <= col_d;
      done_q       <= done_d;
      new_col_q    <= new_col_d;
    end
  end

  assign bus.new_col      = new_col_q;
  assign bus.done_crt     = done_q;
  assign bus.col_idx      = col_q;
  assign bus.period_valid = pvalid_q;
  assign bus.interval     = ival;

endmodule
